// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller for the 5-stage cached MIPS pipeline: forwarding selects,
// load-use/branch stalls, cache-miss sequencing, branch-shadow flush and stall statistics.
module hazard_ctrl_unit #(
  parameter int REG_AW       = 5,
  parameter int MISS_PENALTY = 5,
  parameter int READY_MODE   = 0,
  parameter int BR_SHADOW    = 2,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic              BranchD,
  input  logic              PCSrcE,
  input  logic              hit,
  input  logic              mem_ready,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              miss_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  // state  | meaning
  // IDLE   | no outstanding miss; M access evaluated against hit
  // MISS   | waiting on memory (penalty counter or mem_ready)
  // REFILL | one extra cycle for a load to capture refilled data

  localparam int MCW = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;
  localparam int SCW = (BR_SHADOW > 1) ? $clog2(BR_SHADOW) : 1;
  localparam logic [MCW-1:0] MISS_LOAD   = MCW'(MISS_PENALTY - 1);
  localparam logic [SCW-1:0] SHADOW_LOAD = SCW'(BR_SHADOW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2
  } missState_t;

  missState_t     state;
  missState_t     stateNext;
  logic [MCW-1:0] missCnt;
  logic [SCW-1:0] shadowCnt;
  logic           isLoad;
  logic           missNow;
  logic           missExit;
  logic           missStall;
  logic           flushBr;
  logic           lwStall;
  logic           brStall;
  logic           dataStall;

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src,
                                        input logic              wrM,
                                        input logic [REG_AW-1:0] dstM,
                                        input logic              wrW,
                                        input logic [REG_AW-1:0] dstW);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (wrM && (src == dstM))      sel = 2'b10;
      else if (wrW && (src == dstW)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwdSel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardBE = fwdSel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardAD = RegWriteM && (RsD != '0) && (RsD == WriteRegM);
  assign ForwardBD = RegWriteM && (RtD != '0) && (RtD == WriteRegM);

  assign lwStall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
  assign brStall = BranchD &&
                   ((RegWriteE && (WriteRegE != '0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != '0) &&
                     ((WriteRegM == RsD) || (WriteRegM == RtD))));
  assign dataStall = lwStall || brStall;

  assign missNow   = (state == IDLE) && (MemtoRegM || MemWriteM) && !hit;
  assign missStall = missNow || (state != IDLE);
  assign missExit  = (READY_MODE != 0) ? mem_ready : (missCnt == '0);
  assign flushBr   = (PCSrcE && !missStall) || (shadowCnt != '0);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (missNow) stateNext = MISS;
      MISS:    if (missExit) stateNext = isLoad ? REFILL : IDLE;
      REFILL:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Miss stall outranks the branch flush, which outranks ordinary data stalls.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    miss_busy = (state != IDLE);
    if (missStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (flushBr) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (dataStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      missCnt <= '0;
      isLoad  <= 1'b0;
    end else if (missNow) begin
      missCnt <= MISS_LOAD;
      isLoad  <= MemtoRegM;
    end else if ((state == MISS) && (missCnt != '0)) begin
      missCnt <= missCnt - MCW'(1);
    end
  end

  // Shadow window is frozen while the pipeline is held by a miss.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      shadowCnt <= '0;
    end else if (!missStall) begin
      if (PCSrcE)                shadowCnt <= SHADOW_LOAD;
      else if (shadowCnt != '0)  shadowCnt <= shadowCnt - SCW'(1);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                                  stall_cycles <= '0;
    else if (StallF && (stall_cycles != '1))   stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: fixed-latency and ready-handshake instances share stimulus
// and are compared every cycle against a cycle-count reference model.
module tb_hazard_ctrl_unit;

  logic       CLK;
  logic       CLR;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic       BranchD, PCSrcE, hit, mem_ready;

  logic       StallF [2], StallD [2], StallE [2], StallM [2];
  logic       FlushD [2], FlushE [2], FlushW [2];
  logic [1:0] ForwardAE [2], ForwardBE [2];
  logic       ForwardAD [2], ForwardBD [2], miss_busy [2];
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int vecCount = 0;
  int missCount = 0;

  // reference model state: remaining busy cycles rather than FSM states
  int busyLeft [2];
  bit waitReady [2];
  int refillLeft [2];
  bit pendLoad [2];
  int shadowLeft [2];
  int stallCnt [2];
  int shadowP [2] = '{2, 3};
  int cntMax [2]  = '{65535, 15};
  bit readyM [2]  = '{1'b0, 1'b1};
  localparam int PEN = 5;

  logic sStallF [2], sStallM [2], sFlushD [2], sFlushE [2], sBusy [2];

  hazard_ctrl_unit #(.REG_AW(5), .MISS_PENALTY(PEN), .READY_MODE(0), .BR_SHADOW(2), .CNT_W(16)) dut0 (
    .CLK(CLK), .CLR(CLR), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .PCSrcE(PCSrcE), .hit(hit), .mem_ready(mem_ready),
    .StallF(StallF[0]), .StallD(StallD[0]), .StallE(StallE[0]), .StallM(StallM[0]),
    .FlushD(FlushD[0]), .FlushE(FlushE[0]), .FlushW(FlushW[0]),
    .ForwardAE(ForwardAE[0]), .ForwardBE(ForwardBE[0]),
    .ForwardAD(ForwardAD[0]), .ForwardBD(ForwardBD[0]),
    .miss_busy(miss_busy[0]), .stall_cycles(sc0));

  hazard_ctrl_unit #(.REG_AW(5), .MISS_PENALTY(PEN), .READY_MODE(1), .BR_SHADOW(3), .CNT_W(4)) dut1 (
    .CLK(CLK), .CLR(CLR), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .PCSrcE(PCSrcE), .hit(hit), .mem_ready(mem_ready),
    .StallF(StallF[1]), .StallD(StallD[1]), .StallE(StallE[1]), .StallM(StallM[1]),
    .FlushD(FlushD[1]), .FlushE(FlushE[1]), .FlushW(FlushW[1]),
    .ForwardAE(ForwardAE[1]), .ForwardBE(ForwardBE[1]),
    .ForwardAD(ForwardAD[1]), .ForwardBD(ForwardBD[1]),
    .miss_busy(miss_busy[1]), .stall_cycles(sc1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit busyM(int m);
    if (readyM[m]) return waitReady[m] || (refillLeft[m] > 0);
    return busyLeft[m] > 0;
  endfunction

  function automatic bit missNowM(int m);
    return !busyM(m) && (MemtoRegM || MemWriteM) && !hit;
  endfunction

  function automatic bit missStallM(int m);
    return missNowM(m) || busyM(m);
  endfunction

  function automatic bit flushM(int m);
    return (PCSrcE && !missStallM(m)) || (shadowLeft[m] > 0);
  endfunction

  function automatic bit dataStallM();
    bit lw, br;
    lw = MemtoRegE && (RtE != 0) && (RtE == RsD || RtE == RtD);
    br = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
    return lw || br;
  endfunction

  function automatic logic [7:0] expCtl(int m);
    logic sF, sD, sE, sM, fD, fE, fW;
    {sF, sD, sE, sM, fD, fE, fW} = 7'b0;
    if (missStallM(m)) begin
      {sF, sD, sE, sM, fW} = 5'b11111;
    end else if (flushM(m)) begin
      {fD, fE} = 2'b11;
    end else if (dataStallM()) begin
      {sF, sD, fE} = 3'b111;
    end
    return {sF, sD, sE, sM, fD, fE, fW, busyM(m)};
  endfunction

  function automatic logic [1:0] expFwdE(logic [4:0] src);
    if (src != 0 && RegWriteM && src == WriteRegM) return 2'b10;
    if (src != 0 && RegWriteW && src == WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [5:0] expFwd();
    return {expFwdE(RsE), expFwdE(RtE),
            RegWriteM && RsD != 0 && RsD == WriteRegM,
            RegWriteM && RtD != 0 && RtD == WriteRegM};
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      busyLeft[m] = 0; waitReady[m] = 0; refillLeft[m] = 0;
      pendLoad[m] = 0; shadowLeft[m] = 0; stallCnt[m] = 0;
    end
  endtask

  task automatic modelUpdate();
    for (int m = 0; m < 2; m++) begin
      bit ms, mn, sf;
      logic [7:0] c;
      ms = missStallM(m);
      mn = missNowM(m);
      c  = expCtl(m);
      sf = c[7];
      if (sf && stallCnt[m] < cntMax[m]) stallCnt[m]++;
      if (!ms) begin
        if (PCSrcE) shadowLeft[m] = shadowP[m] - 1;
        else if (shadowLeft[m] > 0) shadowLeft[m]--;
      end
      if (readyM[m]) begin
        if (mn) begin
          waitReady[m] = 1; pendLoad[m] = MemtoRegM;
        end else if (waitReady[m]) begin
          if (mem_ready) begin
            waitReady[m] = 0; refillLeft[m] = pendLoad[m] ? 1 : 0;
          end
        end else if (refillLeft[m] > 0) refillLeft[m]--;
      end else begin
        if (mn) busyLeft[m] = PEN + (MemtoRegM ? 1 : 0);
        else if (busyLeft[m] > 0) busyLeft[m]--;
      end
    end
  endtask

  task automatic checkAll();
    for (int m = 0; m < 2; m++) begin
      checkVal(m == 0 ? "ctl0" : "ctl1",
               {24'b0, StallF[m], StallD[m], StallE[m], StallM[m], FlushD[m], FlushE[m],
                FlushW[m], miss_busy[m]}, {24'b0, expCtl(m)});
      checkVal(m == 0 ? "fwd0" : "fwd1",
               {26'b0, ForwardAE[m], ForwardBE[m], ForwardAD[m], ForwardBD[m]}, {26'b0, expFwd()});
      checkVal(m == 0 ? "cnt0" : "cnt1", m == 0 ? {16'b0, sc0} : {28'b0, sc1}, stallCnt[m]);
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    #1;
    checkAll();
    for (int m = 0; m < 2; m++) begin
      sStallF[m] = StallF[m]; sStallM[m] = StallM[m];
      sFlushD[m] = FlushD[m]; sFlushE[m] = FlushE[m]; sBusy[m] = miss_busy[m];
    end
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
  endtask

  task automatic zeroInputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM} = '0;
    {BranchD, PCSrcE, mem_ready} = '0;
    hit = 1'b1;
  endtask

  task automatic doReset();
    CLR = 1'b0;
    zeroInputs();
    #1;
    modelReset();
    checkVal("rstBusy", {30'b0, miss_busy[0], miss_busy[1]}, 0);
    checkVal("rstCnt", {12'b0, sc1, sc0}, 0);
    CLR = 1'b1;
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
  endtask

  initial begin
    int n, nb;
    CLR = 1'b1;
    zeroInputs();
    #1 CLR = 1'b0;
    repeat (2) @(negedge CLK);
    checkVal("rstCtl0", {StallF[0], StallD[0], StallE[0], StallM[0], FlushD[0], FlushE[0],
                         FlushW[0], miss_busy[0]}, 0);
    doReset();

    // forwarding priority and register zero
    RsE = 5'd3; RegWriteM = 1; WriteRegM = 5'd3; RegWriteW = 1; WriteRegW = 5'd3;
    #1 checkVal("fwdPrio", ForwardAE[0], 2'b10);
    step();
    RsE = 5'd0;
    #1 checkVal("fwdZero", ForwardAE[0], 2'b00);
    step();
    zeroInputs();

    // load-use
    MemtoRegE = 1; RtE = 5'd4; RsD = 5'd4;
    #1 checkVal("lwStall", {StallF[0], StallD[0], FlushE[0], StallE[0]}, 4'b1110);
    step();
    RtE = 5'd0;
    #1 checkVal("lwZero", {StallF[0], StallD[0], FlushE[0]}, 3'b000);
    step();
    zeroInputs();

    // load miss, fixed latency
    doReset();
    MemtoRegM = 1; hit = 0;
    n = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sStallM[0]) n++;
      if (sBusy[0]) nb++;
      hit = 1;
    end
    checkVal("ldMissStall", n, 7);
    checkVal("ldMissBusy", nb, 6);
    checkVal("ldMissCnt", sc0, 7);
    mem_ready = 1; step(); mem_ready = 0; MemtoRegM = 0;
    repeat (3) step();

    // store miss, ready handshake
    doReset();
    MemWriteM = 1; hit = 0;
    n = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ready = (i == 4);
      step();
      if (sStallF[1]) n++;
      if (sBusy[1]) nb++;
      hit = 1;
    end
    checkVal("stMissStall", n, 5);
    checkVal("stMissBusy", nb, 4);
    MemWriteM = 0; mem_ready = 1; step();
    mem_ready = 0; step();
    checkVal("rdyIdle", sBusy[1], 0);

    // taken branch with a coincident load-use
    doReset();
    MemtoRegE = 1; RtE = 5'd4; RsD = 5'd4; PCSrcE = 1;
    step();
    checkVal("brFlush1", {sStallF[0], sFlushD[0], sFlushE[0]}, 3'b011);
    PCSrcE = 0;
    step();
    checkVal("brFlush2", {sStallF[0], sFlushD[0], sFlushE[0]}, 3'b011);
    step();
    checkVal("brAfter", {sStallF[0], sFlushD[0], sFlushE[0]}, 3'b101);
    zeroInputs();

    // branch held during a load miss
    doReset();
    MemtoRegM = 1; hit = 0; PCSrcE = 1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (sFlushD[0]) n++;
      hit = 1;
    end
    checkVal("brInMiss", n, 0);
    step();
    checkVal("brPostMiss", sFlushD[0], 1);
    PCSrcE = 0;
    step();
    checkVal("brShadow", sFlushD[0], 1);
    step();
    checkVal("brDone", sFlushD[0], 0);
    mem_ready = 1; step(); mem_ready = 0; MemtoRegM = 0;
    repeat (3) step();

    // asynchronous reset in the middle of a miss
    doReset();
    MemtoRegM = 1; hit = 0;
    step(); hit = 1; step(); step();
    #3;
    CLR = 1'b0; MemtoRegM = 0;
    #1;
    checkVal("rstMid", {27'b0, miss_busy[0], miss_busy[1], StallF[0], StallM[0], StallF[1]}, 0);
    checkVal("rstMidCnt", {12'b0, sc1, sc0}, 0);
    modelReset();
    CLR = 1'b1;
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 255) == 0) begin
        CLR = 1'b0;
        #1;
        modelReset();
        CLR = 1'b1;
      end
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      MemtoRegM = ($urandom_range(0, 3) == 0); MemWriteM = ($urandom_range(0, 3) == 0);
      BranchD = 1'($urandom_range(0, 1)); PCSrcE = ($urandom_range(0, 7) == 0);
      hit = ($urandom_range(0, 3) != 0); mem_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor hazard/stall controller for the 5-stage cached MIPS pipeline. It provides:
- M/W-to-E forwarding and M-to-D forwarding for branch compare in Decode.
- Load-use and branch-operand stalls.
- A multi-cycle miss FSM for cache misses, in fixed-latency or ready-handshake mode.
- A configurable branch-shadow flush window.
- A saturating stall-cycle counter.

It sits beside the pipeline registers and drives their stall/flush enables.

Parameters:
REG_AW, 5, register-address width
MISS_PENALTY, 5, MISS-state cycles in fixed mode (≥1)
READY_MODE, 0, 0 = fixed latency via counter; 1 = leave MISS on mem_ready
BR_SHADOW, 2, cycles FlushD/FlushE stay asserted after a taken branch (≥1)
CNT_W, 16, stall-cycle counter width

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  asynchronous active-low reset
RsD, RtD, RsE, RtE  in  REG_AW  source registers in D / E
WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destinations in E / M / W
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables
MemtoRegE, MemtoRegM  in  1  load in E / M
MemWriteM  in  1  store in M
BranchD  in  1  branch in D
PCSrcE  in  1  taken branch resolved in E
hit  in  1  data-cache hit for the M access
mem_ready  in  1  refill complete (READY_MODE=1 only)
StallF, StallD, StallE, StallM  out  1  hold pipeline registers
FlushD, FlushE, FlushW  out  1  insert a bubble
ForwardAE, ForwardBE  out  2  10 = from M, 01 = from W, 00 = from register file
ForwardAD, ForwardBD  out  1  forward ALUOutM to the D compare
miss_busy  out  1  FSM not IDLE
stall_cycles  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset (CLR low, asynchronous): FSM to IDLE; miss counter, branch-shadow counter and stall_cycles to 0; miss_busy=0. Combinational outputs then depend only on the data inputs.
- Forwarding (combinational; register 0 never matches):
  - ForwardAE = 10 if RegWriteM and RsE==WriteRegM; else 01 if RegWriteW and RsE==WriteRegW; else 00. M has priority over W.
  - ForwardBE uses the same rule with RtE.
  - ForwardAD = RegWriteM and RsD==WriteRegM; ForwardBD uses RtD.
- lwstall = MemtoRegE and RtE≠0 and (RtE==RsD or RtE==RtD).
- brstall = BranchD and either:
  - RegWriteE with WriteRegE≠0 matching RsD or RtD, or
  - MemtoRegM with WriteRegM≠0 matching RsD or RtD.
- miss_now = IDLE and (MemtoRegM or MemWriteM) and not hit.
- Miss FSM (states IDLE, MISS, REFILL):
  - IDLE→MISS on miss_now. Load counter with MISS_PENALTY−1 and latch is_load=MemtoRegM.
  - MISS, READY_MODE=0: decrement each cycle; exit when counter==0.
  - MISS, READY_MODE=1: counter ignored; exit in the cycle mem_ready=1 is sampled. That cycle is still stalled.
  - On MISS exit: go to REFILL if is_load, else IDLE.
  - REFILL→IDLE after 1 cycle.
  - mem_ready is ignored outside MISS.
- Miss stall (miss_now or MISS or REFILL):
  - StallF=StallD=StallE=StallM=1 and FlushW=1, so there is no duplicate writeback. FlushD=FlushE=0.
  - Fixed-mode total: load miss stalls MISS_PENALTY+2 cycles; store miss stalls MISS_PENALTY+1.
  - After returning to IDLE, the same access is re-evaluated. If hit is still 0, the FSM re-enters MISS.
- Branch shadow:
  - When not miss-stalled and PCSrcE=1, load shadow counter with BR_SHADOW−1.
  - flush_br = (PCSrcE and not miss-stalled) or shadow>0. The counter decrements while >0 and is frozen during a miss stall.
  - When flush_br: FlushD=FlushE=1, StallF=StallD=0. This suppresses data stalls on wrong-path instructions.
- Data stall (lwstall or brstall, with no miss and no flush_br): StallF=StallD=1, FlushE=1; StallE=StallM=0.
- Priority: miss > branch flush > data stall. All stall/flush outputs are 0 when nothing is active.
- stall_cycles increments on each edge where StallF=1 and holds at all-ones.
- Reset mid-miss or mid-shadow aborts immediately to IDLE with counters cleared.

Test Plan:
- Forward priority: RsE=3, RegWriteM=1, WriteRegM=3, RegWriteW=1, WriteRegW=3 → ForwardAE=10. Set RsE=0 → ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=4, RsD=4 → one cycle StallF=StallD=FlushE=1, then clear. With RtE=0 → no stall.
- Load miss, READY_MODE=0, MISS_PENALTY=5: MemtoRegM=1, hit=0 → StallM=FlushW=1 for exactly 7 cycles; miss_busy=1 for 6; then hit=1 → pipeline advances; stall_cycles=7.
- Store miss, READY_MODE=1: MemWriteM=1, hit=0, mem_ready raised 3 cycles after entry → stall lasts 5 cycles and there is no REFILL. A mem_ready pulse while in IDLE has no effect.
- Taken branch, BR_SHADOW=2: PCSrcE=1 for one cycle with lwstall also true → FlushD=FlushE=1 for 2 cycles and StallF=0. A branch during a miss (PCSrcE held) → shadow starts only after the FSM returns to IDLE.
- CLR pulsed low mid-MISS → miss_busy=0 and all stalls drop asynchronously; stall_cycles=0.
